ram_arbiter: RTL and testbench

Two-client arbiter and handshake sequencer sitting directly upstream of the RAM interface (CPU-side modport of `ram_if`). It accepts single-word read/write requests from two requesters (index 0: instruction fetch, index 1: load/store/tensor DMA), grants one at a time with round-robin fairness, and drives `memREN`/`memWEN`/`memaddr`/`memstore` toward RAM. It tracks `ramstate` until the access completes and returns load data, a one-cycle done pulse, or an error pulse on RAM error or timeout.

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-client round-robin arbiter and RAM handshake sequencer
module ram_arbiter #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              r0_ren,
    input  logic              r0_wen,
    input  logic [WORD_W-1:0] r0_addr,
    input  logic [WORD_W-1:0] r0_store,
    output logic [WORD_W-1:0] r0_load,
    output logic              r0_done,
    output logic              r0_err,
    input  logic              r1_ren,
    input  logic              r1_wen,
    input  logic [WORD_W-1:0] r1_addr,
    input  logic [WORD_W-1:0] r1_store,
    output logic [WORD_W-1:0] r1_load,
    output logic              r1_done,
    output logic              r1_err,
    output logic              memREN,
    output logic              memWEN,
    output logic [WORD_W-1:0] memaddr,
    output logic [WORD_W-1:0] memstore,
    input  logic [1:0]        ramstate,
    input  logic [WORD_W-1:0] ramload
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic [WORD_W-1:0] load0_q, load0_d;
    logic [WORD_W-1:0] load1_q, load1_d;

    logic pend0, pend1, sel;

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        write_d      = write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        store_d      = store_q;
        load0_d      = load0_q;
        load1_d      = load1_q;
        pend0        = r0_ren | r0_wen;
        pend1        = r1_ren | r1_wen;
        // On a tie the requester not served last wins.
        sel          = !(pend0 && (!pend1 || last_grant_q));

        case (state_q)
            S_IDLE: begin
                tcnt_d = 8'd0;
                if (pend0 || pend1) begin
                    gnt_d        = sel;
                    last_grant_d = sel;
                    addr_d       = sel ? r1_addr : r0_addr;
                    store_d      = sel ? r1_store : r0_store;
                    write_d      = sel ? r1_wen : r0_wen;
                    err_d        = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                tcnt_d = tcnt_q + 8'd1;
                if (ramstate == RAM_ACCESS) begin
                    if (!write_q) begin
                        if (gnt_q) load1_d = ramload;
                        else       load0_d = ramload;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (ramstate == RAM_ERROR || tcnt_q == TCNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                tcnt_d  = 8'd0;
                state_d = S_IDLE;
            end
            default: begin
                tcnt_d  = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            tcnt_q       <= 8'd0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            store_q      <= '0;
            load0_q      <= '0;
            load1_q      <= '0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            write_q      <= write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            store_q      <= store_d;
            load0_q      <= load0_d;
            load1_q      <= load1_d;
        end
    end

    assign memREN   = (state_q == S_REQ) && !write_q;
    assign memWEN   = (state_q == S_REQ) && write_q;
    assign memaddr  = addr_q;
    assign memstore = store_q;
    assign r0_done  = (state_q == S_RESP) && !gnt_q;
    assign r1_done  = (state_q == S_RESP) && gnt_q;
    assign r0_err   = r0_done && err_q;
    assign r1_err   = r1_done && err_q;
    assign r0_load  = load0_q;
    assign r1_load  = load1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        r0_ren, r0_wen, r1_ren, r1_wen;
    logic [31:0] r0_addr, r0_store, r1_addr, r1_store;
    logic [31:0] r0_load, r1_load;
    logic        r0_done, r0_err, r1_done, r1_err;
    logic        memREN, memWEN;
    logic [31:0] memaddr, memstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] load;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] exp_load0, exp_load1;
    int          n_checks = 0;
    int          n_fail = 0;

    ram_arbiter #(.WORD_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .r0_ren(r0_ren), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_store(r0_store),
        .r0_load(r0_load), .r0_done(r0_done), .r0_err(r0_err),
        .r1_ren(r1_ren), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_store(r1_store),
        .r1_load(r1_load), .r1_done(r1_done), .r1_err(r1_err),
        .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr), .memstore(memstore),
        .ramstate(ramstate), .ramload(ramload)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        r0_ren = 0; r0_wen = 0; r1_ren = 0; r1_wen = 0;
        r0_addr = '0; r0_store = '0; r1_addr = '0; r1_store = '0;
        ramstate = FREE; ramload = '0;
        exp_load0 = '0; exp_load1 = '0;
        step();
        step();
        @(negedge CLK);
        n_checks++;
        if ({memREN, memWEN, r0_done, r1_done, r0_err, r1_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {memREN, memWEN, r0_done, r1_done, r0_err, r1_err});
        end
        n_checks++;
        if ({memaddr, memstore, r0_load, r1_load} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {memaddr, memstore, r0_load, r1_load});
        end
        nRST = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        r0_ren = 1; r0_addr = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
        sb.push_back('{0, 1'b0, 32'hDEADBEEF});
        exp_load0 = 32'hDEADBEEF;
        step();
        r0_ren = 0;
        @(negedge CLK);
        n_checks++;
        if ({memREN, memWEN, memaddr} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL read_strobe: got ren=%b wen=%b addr=%h expected 1 0 00000100", memREN, memWEN, memaddr);
        end
        step();
        ramstate = FREE;
        @(negedge CLK);
        n_checks++;
        if ({r0_done, r1_done, memREN} !== 3'b100) begin
            n_fail++;
            $display("FAIL read_done: got done0=%b done1=%b ren=%b expected 1 0 0", r0_done, r1_done, memREN);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL read_sb: got empty scoreboard expected 1 entry");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({r0_err, r0_load} !== {e.err, e.load}) begin
                n_fail++;
                $display("FAIL read_data: got err=%b load=%h expected %b %h", r0_err, r0_load, e.err, e.load);
            end
        end
        step();
    endtask

    task automatic test_write_wait();
        int wen_cycles = 0;
        r1_ren = 1; r1_wen = 1; r1_addr = 32'h40; r1_store = 32'h12345678;
        ramstate = BUSY;
        sb.push_back('{1, 1'b0, exp_load1});
        for (int i = 1; i <= 4; i++) begin
            step();
            r1_ren = 0; r1_wen = 0; r1_addr = 32'hFFFF; r1_store = 32'h0;
            ramstate = (i == 4) ? ACCESS : BUSY;
            ramload = 32'hBAD0BAD0;
            @(negedge CLK);
            if (memWEN) wen_cycles++;
            n_checks++;
            if ({memREN, memaddr, memstore} !== {1'b0, 32'h40, 32'h12345678}) begin
                n_fail++;
                $display("FAIL write_stable c%0d: got ren=%b addr=%h data=%h expected 0 00000040 12345678", i, memREN, memaddr, memstore);
            end
        end
        n_checks++;
        if (wen_cycles !== 4) begin
            n_fail++;
            $display("FAIL write_wen_len: got %0d expected 4", wen_cycles);
        end
        step();
        ramstate = FREE;
        @(negedge CLK);
        n_checks++;
        if ({r1_done, r0_done, memWEN} !== 3'b100) begin
            n_fail++;
            $display("FAIL write_done: got done1=%b done0=%b wen=%b expected 1 0 0", r1_done, r0_done, memWEN);
        end
        e = sb.pop_front();
        n_checks++;
        if ({r1_err, r1_load} !== {e.err, e.load}) begin
            n_fail++;
            $display("FAIL write_load: got err=%b load=%h expected %b %h", r1_err, r1_load, e.err, e.load);
        end
        step();
    endtask

    task automatic test_contention();
        int g;
        nRST = 0;
        r0_ren = 1; r0_addr = 32'h200; r1_ren = 1; r1_addr = 32'h300;
        ramstate = ACCESS;
        exp_load0 = '0; exp_load1 = '0;
        sb.delete();
        step();
        nRST = 1;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            ramload = 32'hC0DE0000 + k;
            sb.push_back('{g, 1'b0, ramload});
            step();
            @(negedge CLK);
            n_checks++;
            if ({memREN, memaddr} !== {1'b1, (g == 1) ? 32'h300 : 32'h200}) begin
                n_fail++;
                $display("FAIL contention_grant k%0d: got ren=%b addr=%h expected grant %0d", k, memREN, memaddr, g);
            end
            step();
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if ({r0_done, r1_done} !== ((e.idx == 1) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL contention_done k%0d: got done0=%b done1=%b expected only %0d", k, r0_done, r1_done, e.idx);
            end
            if (e.idx == 1) exp_load1 = e.load;
            else            exp_load0 = e.load;
            n_checks++;
            if ({r0_load, r1_load} !== {exp_load0, exp_load1}) begin
                n_fail++;
                $display("FAIL contention_load k%0d: got %h %h expected %h %h", k, r0_load, r1_load, exp_load0, exp_load1);
            end
            step();
        end
        r0_ren = 0; r1_ren = 0; ramstate = FREE;
        step();
    endtask

    task automatic test_error();
        r0_ren = 1; r0_addr = 32'h500; ramstate = BUSY; ramload = 32'h11111111;
        sb.push_back('{0, 1'b1, exp_load0});
        step();
        r0_ren = 0;
        step();
        ramstate = ERROR;
        @(negedge CLK);
        n_checks++;
        if (memREN !== 1'b1) begin
            n_fail++;
            $display("FAIL error_ren: got %b expected 1", memREN);
        end
        step();
        ramstate = FREE;
        @(negedge CLK);
        e = sb.pop_front();
        n_checks++;
        if ({r0_done, r0_err, r1_done, r0_load} !== {2'b11, 1'b0, e.load}) begin
            n_fail++;
            $display("FAIL error_resp: got done=%b err=%b done1=%b load=%h expected 1 1 0 %h", r0_done, r0_err, r1_done, r0_load, e.load);
        end
        step();
        @(negedge CLK);
        n_checks++;
        if ({r0_done, r0_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL error_pulse_len: got done=%b err=%b expected 0 0", r0_done, r0_err);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        bit seen = 0;
        step();
        r1_ren = 1; r1_addr = 32'h700; ramstate = BUSY; ramload = 32'h22222222;
        sb.push_back('{1, 1'b1, exp_load1});
        step();
        r1_ren = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (memREN) req_cycles++;
            if (r0_done || r1_done) seen = 1;
            else step();
        end
        n_checks++;
        if (!seen || req_cycles !== 4) begin
            n_fail++;
            $display("FAIL timeout_len: got done_seen=%0d req_cycles=%0d expected 1 4", seen, req_cycles);
        end
        e = sb.pop_front();
        n_checks++;
        if ({r1_done, r1_err, r0_done, r1_load} !== {2'b11, 1'b0, e.load}) begin
            n_fail++;
            $display("FAIL timeout_resp: got done=%b err=%b done0=%b load=%h expected 1 1 0 %h", r1_done, r1_err, r0_done, r1_load, e.load);
        end
        step();
        @(negedge CLK);
        n_checks++;
        if ({memREN, memWEN, r1_done, r1_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: got %b expected 0000", {memREN, memWEN, r1_done, r1_err});
        end
        ramstate = FREE;
    endtask

    task automatic test_reset_mid();
        step();
        r0_wen = 1; r0_addr = 32'h900; r0_store = 32'h55; ramstate = BUSY;
        step();
        r0_wen = 0;
        @(negedge CLK);
        n_checks++;
        if (memWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_wen: got %b expected 1", memWEN);
        end
        nRST = 0;
        step();
        @(negedge CLK);
        exp_load0 = '0; exp_load1 = '0;
        n_checks++;
        if ({memREN, memWEN, r0_done, r1_done, memaddr, memstore, r0_load, r1_load} !== {4'b0, 128'b0}) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ren=%b wen=%b done=%b%b addr=%h data=%h loads=%h %h expected all 0", memREN, memWEN, r0_done, r1_done, memaddr, memstore, r0_load, r1_load);
        end
        nRST = 1;
        r0_ren = 1; r0_addr = 32'hA00; r1_ren = 1; r1_addr = 32'hB00;
        step();
        r0_ren = 0; r1_ren = 0; ramstate = ACCESS; ramload = 32'h77;
        sb.push_back('{0, 1'b0, 32'h77});
        @(negedge CLK);
        n_checks++;
        if ({memREN, memaddr} !== {1'b1, 32'hA00}) begin
            n_fail++;
            $display("FAIL rstmid_first_grant: got ren=%b addr=%h expected 1 00000a00", memREN, memaddr);
        end
        step();
        ramstate = FREE;
        @(negedge CLK);
        e = sb.pop_front();
        n_checks++;
        if ({r0_done, r1_done, r0_err, r0_load} !== {3'b100, e.load}) begin
            n_fail++;
            $display("FAIL rstmid_done: got done0=%b done1=%b err=%b load=%h expected 1 0 0 %h", r0_done, r1_done, r0_err, r0_load, e.load);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_contention();
        test_error();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
